// File: rtl/data_memory_sized.sv
// RV32I data memory: byte-addressed, word-organised, registered read with fault reporting
// and a sequential clear engine that zeroes every word after reset.
module data_memory_sized #(
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [2:0]  funct3,
    output logic [31:0] readData,
    output logic        readValid,
    output logic        fault,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] clearIdx_q, clearIdx_d;
    logic [31:0]   readData_q, readData_d;
    logic          readValid_q, readValid_d;
    logic          fault_q, fault_d;

    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic          isStore;
    logic          isLoad;
    logic          outOfRange;
    logic          misaligned;
    logic          illegalOp;
    logic          reqFault;
    logic          storeCommit;
    logic          clearWrite;
    logic [3:0]    byteEn;
    logic [31:0]   storeWord;
    logic [31:0]   laneShifted;
    logic [31:0]   loadValue;

    assign wordIdx = address[AW+1:2];
    assign lane    = address[1:0];
    assign isStore = memWrite;
    assign isLoad  = memRead & ~memWrite;

    // Request classification: any of range, alignment or opcode problems rejects the access.
    always_comb begin
        outOfRange = (address[31:AW+2] != '0);
        misaligned = 1'b0;
        illegalOp  = 1'b0;
        case (funct3)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = lane[0];
            3'b010:  misaligned = (lane != 2'b00);
            3'b100:  illegalOp  = isStore;
            3'b101: begin
                misaligned = lane[0];
                illegalOp  = isStore;
            end
            default: illegalOp  = 1'b1;
        endcase
        reqFault = (isStore | isLoad) & (outOfRange | misaligned | illegalOp);
    end

    assign clearWrite  = (state_q == CLEAR);
    assign storeCommit = (state_q == IDLE) & isStore & ~reqFault;

    always_comb begin
        byteEn    = 4'b0000;
        storeWord = writeData;
        case (funct3)
            3'b000: begin
                byteEn    = 4'b0001 << lane;
                storeWord = {4{writeData[7:0]}};
            end
            3'b001: begin
                byteEn    = lane[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{writeData[15:0]}};
            end
            3'b010: begin
                byteEn    = 4'b1111;
                storeWord = writeData;
            end
            default: begin
                byteEn    = 4'b0000;
                storeWord = writeData;
            end
        endcase
    end

    always_comb begin
        laneShifted = mem[wordIdx] >> {lane, 3'b000};
        loadValue   = laneShifted;
        case (funct3)
            3'b000:  loadValue = {{24{laneShifted[7]}}, laneShifted[7:0]};
            3'b001:  loadValue = {{16{laneShifted[15]}}, laneShifted[15:0]};
            3'b100:  loadValue = {24'b0, laneShifted[7:0]};
            3'b101:  loadValue = {16'b0, laneShifted[15:0]};
            default: loadValue = laneShifted;
        endcase
    end

    // Storage is not reset; the clear engine zeroes it word by word instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clearWrite) begin
                mem[clearIdx_q] <= '0;
            end else if (storeCommit) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteEn[b]) begin
                        mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clearIdx_d  = clearIdx_q;
        readData_d  = readData_q;
        readValid_d = 1'b0;
        fault_d     = 1'b0;
        case (state_q)
            CLEAR: begin
                clearIdx_d = clearIdx_q + 1'b1;
                if (clearIdx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (isStore) begin
                    fault_d = reqFault;
                end else if (isLoad) begin
                    readValid_d = 1'b1;
                    fault_d     = reqFault;
                    readData_d  = reqFault ? 32'h0 : loadValue;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            clearIdx_q  <= '0;
            readData_q  <= '0;
            readValid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clearIdx_q  <= clearIdx_d;
            readData_q  <= readData_d;
            readValid_q <= readValid_d;
            fault_q     <= fault_d;
        end
    end

    assign readData  = readData_q;
    assign readValid = readValid_q;
    assign fault     = fault_q;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH=64, clear on reset): loads/stores of every
// width, fault cases, combined request, back-to-back loads and reset mid-clear.
module tb_data_memory_sized;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [2:0]  funct3;
    logic [31:0] readData;
    logic        readValid;
    logic        fault;
    logic        busy;

    int checks;
    int failures;
    int busyCycles;

    data_memory_sized #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .writeData (writeData),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .funct3    (funct3),
        .readData  (readData),
        .readValid (readValid),
        .fault     (fault),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        memWrite  = wr;
        memRead   = rd;
        funct3    = f3;
        address   = addr;
        writeData = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request for one cycle, then leave the bus idle.
    task automatic request(input logic wr, input logic rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(wr, rd, f3, addr, data);
        tick();
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] expected);
        request(1'b0, 1'b1, f3, addr, 32'h0);
        checkOutput({tag, " valid"}, {31'b0, readValid}, 32'h1);
        checkOutput({tag, " fault"}, {31'b0, fault}, 32'h0);
        checkOutput({tag, " data"}, readData, expected);
    endtask

    task automatic waitClear();
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 200) begin
            tick();
            busyCycles++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset readData", readData, 32'h0);
        checkOutput("reset readValid", {31'b0, readValid}, 32'h0);
        checkOutput("reset fault", {31'b0, fault}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h1);

        // Load while clearing must be ignored.
        request(1'b0, 1'b1, 3'b010, 32'h0FC, 32'h0);
        checkOutput("busy load valid", {31'b0, readValid}, 32'h0);
        waitClear();
        checkOutput("clear length", 32'(busyCycles + 1), 32'd64);
        load("cleared LW 0xFC", 3'b010, 32'h0FC, 32'h0);

        request(1'b1, 1'b0, 3'b010, 32'h10, 32'h8899AABB);
        checkOutput("SW fault", {31'b0, fault}, 32'h0);
        checkOutput("SW valid", {31'b0, readValid}, 32'h0);
        request(1'b1, 1'b0, 3'b000, 32'h11, 32'h0000007F);
        load("LW 0x10", 3'b010, 32'h10, 32'h88997FBB);
        load("LB 0x13", 3'b000, 32'h13, 32'hFFFFFF88);
        load("LBU 0x13", 3'b100, 32'h13, 32'h00000088);

        request(1'b1, 1'b0, 3'b001, 32'h22, 32'h0000F00D);
        load("LH 0x22", 3'b001, 32'h22, 32'hFFFFF00D);
        load("LHU 0x22", 3'b101, 32'h22, 32'h0000F00D);
        load("LW 0x20", 3'b010, 32'h20, 32'hF00D0000);

        request(1'b0, 1'b1, 3'b010, 32'h06, 32'h0);
        checkOutput("LW 0x06 fault", {31'b0, fault}, 32'h1);
        checkOutput("LW 0x06 valid", {31'b0, readValid}, 32'h1);
        checkOutput("LW 0x06 data", readData, 32'h0);
        request(1'b1, 1'b0, 3'b001, 32'h21, 32'h0000FFFF);
        checkOutput("SH 0x21 fault", {31'b0, fault}, 32'h1);
        checkOutput("SH 0x21 valid", {31'b0, readValid}, 32'h0);
        request(1'b1, 1'b0, 3'b100, 32'h20, 32'h000000AA);
        checkOutput("store BU fault", {31'b0, fault}, 32'h1);
        load("LW 0x20 unchanged", 3'b010, 32'h20, 32'hF00D0000);
        request(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
        checkOutput("LW 0x100 fault", {31'b0, fault}, 32'h1);
        checkOutput("LW 0x100 data", readData, 32'h0);
        request(1'b0, 1'b1, 3'b011, 32'h10, 32'h0);
        checkOutput("funct3 011 fault", {31'b0, fault}, 32'h1);

        request(1'b1, 1'b1, 3'b010, 32'h30, 32'h12345678);
        checkOutput("rd+wr valid", {31'b0, readValid}, 32'h0);
        checkOutput("rd+wr fault", {31'b0, fault}, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h30, 32'h0);
        tick();
        checkOutput("b2b first valid", {31'b0, readValid}, 32'h1);
        checkOutput("b2b first data", readData, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        tick();
        checkOutput("b2b second valid", {31'b0, readValid}, 32'h1);
        checkOutput("b2b second data", readData, 32'h88997FBB);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();
        checkOutput("idle valid", {31'b0, readValid}, 32'h0);
        checkOutput("idle hold data", readData, 32'h88997FBB);

        // Reset partway through a clear pass restarts the full sweep.
        request(1'b1, 1'b0, 3'b010, 32'h40, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("mid-clear busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waitClear();
        checkOutput("restart clear length", 32'(busyCycles), 32'd64);
        load("LW 0x40 after clear", 3'b010, 32'h40, 32'h0);
        load("LW 0x10 after clear", 3'b010, 32'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
